// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// selectable registered or first-word-fall-through read, sticky error flags and flush.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg, underflow_reg;
  logic              rd_acc, wr_acc;

  // Flags decode straight from the registered count, so they track it with no lag.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CNT_W'(DEPTH));
  assign almost_full  = (count_reg >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_reg <= CNT_W'(AE_THRESH));
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A full FIFO may still take a write when a read frees the slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      count_reg <= count_next;
      if (wr_en & ~wr_acc) overflow_reg  <= 1'b1;
      if (rd_en & empty)   underflow_reg <= 1'b1;
    end
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc & ~flush & ~rst) mem[wr_ptr_reg] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr_reg];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      // Registered read sees the pre-write word when head and tail coincide (full).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else if (flush) begin
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one standard-read and one FWFT instance.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  // standard-read instance
  logic       flush0, wr_en0, rd_en0;
  logic [7:0] wr_data0, rd_data0;
  logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [6:0] count0;
  // FWFT instance
  logic       flush1, wr_en1, rd_en1;
  logic [7:0] wr_data1, rd_data1;
  logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [6:0] count1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] q [$];
  logic [7:0] exp_d;
  logic [7:0] v;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .wr_en(wr_en0), .wr_data(wr_data0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {flush0, wr_en0, rd_en0, flush1, wr_en1, rd_en1} = '0;
    wr_data0 = '0;
    wr_data1 = '0;
    repeat (3) tick();

    // 1: reset state
    check("rst_empty", empty0, 1);
    check("rst_aempty", ae0, 1);
    check("rst_count", count0, 0);
    check("rst_valid", rd_valid0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_unf", unf0, 0);
    check("rst_full", full0, 0);
    check("rst_afull", af0, 0);
    check("rst_data", rd_data0, 0);
    check("rst_fwft_valid", rd_valid1, 0);
    rst = 1'b0;
    tick();

    // 2: fill to full, almost_full boundary, overflow
    for (int i = 0; i < 64; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(i);
      tick();
      if (i == 54) check("af_at55", af0, 0);
      if (i == 55) check("af_at56", af0, 1);
      if (i == 7)  check("ae_at8", ae0, 1);
      if (i == 8)  check("ae_at9", ae0, 0);
    end
    check("fill_full", full0, 1);
    check("fill_count", count0, 64);
    wr_data0 = 8'hEE;
    tick();
    wr_en0 = 1'b0;
    check("ovf_set", ovf0, 1);
    check("ovf_count", count0, 64);

    // 3: drain with one-cycle latency, then underflow
    for (int i = 0; i < 64; i++) begin
      rd_en0 = 1'b1;
      tick();
      check($sformatf("rd%0d", i), rd_data0, 32'(i));
      check($sformatf("rv%0d", i), rd_valid0, 1);
    end
    tick();
    rd_en0 = 1'b0;
    check("unf_set", unf0, 1);
    check("unf_valid", rd_valid0, 0);
    check("drain_empty", empty0, 1);

    // 4: simultaneous read/write while full
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    check("flush_ovf", ovf0, 0);
    check("flush_unf", unf0, 0);
    for (int i = 0; i < 64; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(i);
      tick();
    end
    wr_data0 = 8'hA5; rd_en0 = 1'b1;
    tick();
    wr_en0 = 1'b0;
    check("fullrw_count", count0, 64);
    check("fullrw_ovf", ovf0, 0);
    check("fullrw_rbw", rd_data0, 0);
    for (int i = 1; i < 64; i++) begin
      tick();
      check($sformatf("fullrd%0d", i), rd_data0, 32'(i));
    end
    tick();
    rd_en0 = 1'b0;
    check("a5_out", rd_data0, 32'hA5);
    check("a5_empty", empty0, 1);

    // 5: FWFT, simultaneous read/write on empty
    wr_en1 = 1'b1; rd_en1 = 1'b1; wr_data1 = 8'h3C;
    tick();
    wr_en1 = 1'b0; rd_en1 = 1'b0;
    check("fwft_count", count1, 1);
    check("fwft_unf", unf1, 1);
    check("fwft_valid", rd_valid1, 1);
    check("fwft_data", rd_data1, 32'h3C);
    wr_en1 = 1'b1; wr_data1 = 8'h5A;
    tick();
    wr_en1 = 1'b0; rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check("fwft_pop_data", rd_data1, 32'h5A);
    check("fwft_pop_count", count1, 1);
    flush1 = 1'b1; wr_en1 = 1'b1;
    tick();
    flush1 = 1'b0; wr_en1 = 1'b0;
    check("fwft_flush_count", count1, 0);
    check("fwft_flush_unf", unf1, 0);
    check("fwft_flush_valid", rd_valid1, 0);

    // 6: wraparound streaming at count 30, then flush mid-stream
    for (int k = 0; k < 30; k++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(k + 8'h80);
      q.push_back(wr_data0);
      tick();
    end
    check("pre_count", count0, 30);
    for (int i = 0; i < 200; i++) begin
      v = 8'((i * 7 + 3) & 8'hFF);
      wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = v;
      tick();
      exp_d = q.pop_front();
      q.push_back(v);
      check($sformatf("wrap%0d", i), rd_data0, 32'(exp_d));
    end
    check("wrap_count", count0, 30);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0;
    check("flush_count", count0, 0);
    check("flush_empty", empty0, 1);
    check("flush_valid", rd_valid0, 0);
    check("flush_hold", rd_data0, 32'(exp_d));

    // asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(k);
      tick();
    end
    wr_en0 = 1'b0;
    check("pre_rst_count", count0, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", count0, 0);
    check("async_rst_empty", empty0, 1);
    check("async_rst_data", rd_data0, 0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
